sel_scan_master: RTL and testbench

Bus-side initiator for the input-mux channel-select register. It walks a channel range, and for each channel:
- writes an enable-off word, polls until the mux reports inactive;
- writes the channel-select word with enable set, polls until active;
- waits a settle time, then hands one measurement slot to the acquisition logic.

It sits between the calibration/acquisition controller and the register's bus port, in place of host-driven PCI cycles.

---
 rtl/sel_scan_master.sv | 165 ++++++++++++++++
 tb/tb_sel_scan_master.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sel_scan_master.sv
// rtl/sel_scan_master.sv - bus initiator that scans input-mux channels through the channel-select register
//
// Walks ch_first..ch_last. For each channel it switches the mux off, then on,
// waits for the settle time and hands one measurement slot to acquisition.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start, abort, cont       scan control (cont is latched at start)
//   ch_first, ch_last        channel range, checked against CH_MAX at start
//   meas_done                acquisition finished the current slot
//   data_in_1_sel, rd_wr,
//   valid_pci, ad_to_tuvv    register bus: one-cycle writes and reads
//   ad_from_tuvv             read data: [9] active, [8] En, [7:0] channel
//   busy, cur_ch             scan in progress, channel currently selected
//   meas_strobe, done        measurement slot start, scan ended
//   err                      sticky code: 0 none, 1 range, 2 off-timeout, 3 on-timeout
module sel_scan_master #(
  parameter int SETTLE_CYC  = 50,
  parameter int POLL_GAP    = 4,
  parameter int TIMEOUT_CYC = 4096,
  parameter int CH_MAX      = 156
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic        cont,
  input  logic [7:0]  ch_first,
  input  logic [7:0]  ch_last,
  input  logic        meas_done,
  output logic        data_in_1_sel,
  output logic        rd_wr,
  output logic        valid_pci,
  output logic [31:0] ad_to_tuvv,
  input  logic [31:0] ad_from_tuvv,
  output logic        busy,
  output logic [7:0]  cur_ch,
  output logic        meas_strobe,
  output logic        done,
  output logic [1:0]  err
);

  localparam int CNT_MAX = (TIMEOUT_CYC > SETTLE_CYC) ? TIMEOUT_CYC : SETTLE_CYC;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int GW      = $clog2(POLL_GAP + 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYC - 1);
  localparam logic [CW-1:0] SET_LAST = CW'(SETTLE_CYC - 1);
  localparam logic [GW-1:0] GAP_L    = GW'(POLL_GAP);
  localparam logic [7:0]    CH_MAX_L = 8'(CH_MAX);

  typedef enum logic [3:0] {
    IDLE, WR_OFF, POLL_OFF, WR_ON, POLL_ON, SETTLE, MEAS, NEXT, SHUTDOWN
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt;        // cycles in current state; timeout, settle and MEAS first-cycle
  logic [GW-1:0] gap_cnt;    // idle cycles since last poll access
  logic [7:0]    first_q, last_q;
  logic          cont_q;
  logic          rng_done;   // done pulse for a rejected start
  logic          wr_cyc, rd_cyc, poll_ok, poll_to, range_bad;

  // Read-data bits the scan never looks at.
  logic unused_rd_bits;
  assign unused_rd_bits = ^{ad_from_tuvv[31:10], ad_from_tuvv[8]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      gap_cnt  <= '0;
      cur_ch   <= 8'd0;
      first_q  <= 8'd0;
      last_q   <= 8'd0;
      cont_q   <= 1'b0;
      err      <= 2'd0;
      rng_done <= 1'b0;
    end else begin
      state    <= state_n;
      rng_done <= 1'b0;
      if (state_n != state) begin
        cnt     <= '0;
        gap_cnt <= '0;
      end else begin
        // Saturate so a long MEAS wait never wraps back to a fresh strobe.
        if (cnt != '1) cnt <= cnt + 1'b1;
        gap_cnt <= rd_cyc ? '0 : gap_cnt + 1'b1;
      end
      case (state)
        IDLE: if (start && !abort) begin
          if (range_bad) begin
            err      <= 2'd1;
            rng_done <= 1'b1;
          end else begin
            first_q <= ch_first;
            last_q  <= ch_last;
            cont_q  <= cont;
            cur_ch  <= ch_first;
            err     <= 2'd0;
          end
        end
        POLL_OFF: if (poll_to && !poll_ok && !abort) err <= 2'd2;
        POLL_ON:  if (poll_to && !poll_ok && !abort) err <= 2'd3;
        NEXT: if (!abort) begin
          if (cur_ch < last_q) cur_ch <= cur_ch + 8'd1;
          else if (cont_q)     cur_ch <= first_q;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_n   = state;
    wr_cyc    = 1'b0;
    rd_cyc    = 1'b0;
    poll_ok   = 1'b0;
    poll_to   = 1'b0;
    range_bad = (ch_first > ch_last) || (ch_last > CH_MAX_L);
    case (state)
      IDLE:     if (start && !abort && !range_bad) state_n = WR_OFF;
      WR_OFF: begin
        wr_cyc  = 1'b1;
        state_n = POLL_OFF;
      end
      POLL_OFF: begin
        rd_cyc  = (gap_cnt == GAP_L);
        poll_ok = rd_cyc && !ad_from_tuvv[9];
        poll_to = (cnt == TO_LAST);
        if (poll_ok)      state_n = WR_ON;
        else if (poll_to) state_n = SHUTDOWN;
      end
      WR_ON: begin
        wr_cyc  = 1'b1;
        state_n = POLL_ON;
      end
      POLL_ON: begin
        rd_cyc  = (gap_cnt == GAP_L);
        poll_ok = rd_cyc && ad_from_tuvv[9] && (ad_from_tuvv[7:0] == cur_ch);
        poll_to = (cnt == TO_LAST);
        if (poll_ok)      state_n = SETTLE;
        else if (poll_to) state_n = SHUTDOWN;
      end
      SETTLE:   if (cnt == SET_LAST) state_n = MEAS;
      // cnt != 0 keeps meas_done from being taken in the strobe cycle.
      MEAS:     if (cnt != '0 && meas_done) state_n = NEXT;
      NEXT:     state_n = (cur_ch < last_q || cont_q) ? WR_OFF : SHUTDOWN;
      SHUTDOWN: begin
        wr_cyc  = 1'b1;
        state_n = IDLE;
      end
      default:  state_n = IDLE;
    endcase
    if (abort && state != IDLE && state != SHUTDOWN) state_n = SHUTDOWN;

    data_in_1_sel = wr_cyc || rd_cyc;
    rd_wr         = wr_cyc;
    valid_pci     = wr_cyc;
    ad_to_tuvv    = wr_cyc ? {23'd0, (state == WR_ON), cur_ch} : 32'd0;
    busy          = (state != IDLE);
    meas_strobe   = (state == MEAS) && (cnt == '0);
    done          = (state == SHUTDOWN) || rng_done;
  end

endmodule

// File: tb/tb_sel_scan_master.sv
// tb/tb_sel_scan_master.sv - directed self-checking bench for sel_scan_master
module tb_sel_scan_master;
  localparam int SETTLE = 5;
  localparam int GAP    = 2;
  localparam int TMO    = 64;
  localparam int CHM    = 156;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0, cont = 1'b0, meas_done = 1'b0;
  logic [7:0] ch_first = 8'd0, ch_last = 8'd0;
  logic data_in_1_sel, rd_wr, valid_pci, busy, meas_strobe, done;
  logic [31:0] ad_to_tuvv, ad_from_tuvv;
  logic [7:0] cur_ch;
  logic [1:0] err;

  sel_scan_master #(.SETTLE_CYC(SETTLE), .POLL_GAP(GAP), .TIMEOUT_CYC(TMO), .CH_MAX(CHM)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .cont(cont),
    .ch_first(ch_first), .ch_last(ch_last), .meas_done(meas_done),
    .data_in_1_sel(data_in_1_sel), .rd_wr(rd_wr), .valid_pci(valid_pci),
    .ad_to_tuvv(ad_to_tuvv), .ad_from_tuvv(ad_from_tuvv), .busy(busy),
    .cur_ch(cur_ch), .meas_strobe(meas_strobe), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  task automatic chk_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Mux register model: active follows En 10 cycles after each write.
  // mode 0 normal, 1 never goes active, 2 echoes a wrong channel while active.
  int mode = 0;
  logic m_en = 1'b0, m_act = 1'b0;
  logic [7:0] m_ch = 8'd0;
  int m_cnt = 0;
  always @(posedge clk) begin
    if (data_in_1_sel && rd_wr && valid_pci) begin
      m_en  <= ad_to_tuvv[8];
      m_ch  <= ad_to_tuvv[7:0];
      m_cnt <= 10;
    end else if (m_cnt > 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) m_act <= (mode == 1) ? 1'b0 : m_en;
    end
  end
  assign ad_from_tuvv = {22'd0, m_act, m_en, (mode == 2 && m_act) ? (m_ch ^ 8'h01) : m_ch};

  // Acquisition model: meas_done three cycles after each strobe.
  int md_cnt = 0;
  always @(negedge clk) begin
    meas_done = 1'b0;
    if (md_cnt > 0) begin
      md_cnt--;
      if (md_cnt == 0) meas_done = 1'b1;
    end
    if (meas_strobe && !rst) md_cnt = 3;
  end

  // Scoreboard: expected bus writes and strobe channels, checked every cycle.
  logic [31:0] exp_wr[$];
  logic [7:0]  exp_ch[$];
  int n_strobe = 0, n_done = 0, rd_count = 0, cyc = 0, last_acc = -100;
  logic wr_now;
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      last_acc = -100;
    end else begin
      wr_now = data_in_1_sel && rd_wr;
      chk_eq("valid_pci_only_on_write", valid_pci, wr_now);
      if (!wr_now) chk_eq("ad_to_tuvv_idle_zero", ad_to_tuvv, 0);
      if (wr_now) begin
        if (exp_wr.size() == 0) chk_eq("unexpected_write", ad_to_tuvv, 64'hDEAD);
        else chk_eq("write_word", ad_to_tuvv, exp_wr.pop_front());
        last_acc = cyc;
      end
      if (data_in_1_sel && !rd_wr) begin
        chk_eq("read_spacing", cyc - last_acc, GAP + 1);
        last_acc = cyc;
        rd_count++;
      end
      if (meas_strobe) begin
        n_strobe++;
        if (exp_ch.size() == 0) chk_eq("unexpected_strobe", cur_ch, 64'hDEAD);
        else chk_eq("strobe_channel", cur_ch, exp_ch.pop_front());
      end
      if (done) begin
        n_done++;
        if (busy) chk_eq("done_with_off_write", {wr_now, ad_to_tuvv[8]}, 2'b10);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_start(input logic [7:0] f, input logic [7:0] l, input logic c, input bit scan);
    @(negedge clk);
    ch_first = f; ch_last = l; cont = c; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (scan) chk_eq("start_to_first_write", {data_in_1_sel, rd_wr}, 2'b11);
  endtask

  task automatic wait_done(input int bound);
    int k = 0;
    while (!done && k < bound) begin
      @(negedge clk);
      k++;
    end
    if (!done) chk_eq("done_timeout", k, bound + 1);
    else begin
      chk_eq("busy_at_done", busy, 1);
      @(negedge clk);
      chk_eq("busy_after_done", busy, 0);
      chk_eq("done_one_cycle", done, 0);
    end
  endtask

  task automatic end_test();
    idle(20);
    chk_eq("writes_outstanding", exp_wr.size(), 0);
    chk_eq("strobes_outstanding", exp_ch.size(), 0);
  endtask

  function automatic logic [31:0] wword(input logic en, input logic [7:0] ch);
    return {23'd0, en, ch};
  endfunction

  initial begin
    int rd0, k;
    logic [7:0] c;
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int rd0, k;
    logic [7:0] c;
    // Reset state
    idle(3);
    chk_eq("reset_outputs",
           {data_in_1_sel, rd_wr, valid_pci, busy, meas_strobe, done, err, cur_ch, ad_to_tuvv}, 0);
    rst = 1'b0;
    idle(2);

    // Range errors: reversed range and last beyond CH_MAX
    n_done = 0; rd0 = rd_count;
    do_start(8'd7, 8'd2, 1'b0, 1'b0);
    chk_eq("range_err_done", done, 1);
    chk_eq("range_err_code", err, 1);
    chk_eq("range_err_busy", busy, 0);
    @(negedge clk);
    chk_eq("range_err_done_pulse", done, 0);
    idle(5);
    chk_eq("range_err_done_count", n_done, 1);
    chk_eq("range_err_no_reads", rd_count - rd0, 0);
    do_start(8'd0, 8'd157, 1'b0, 1'b0);
    chk_eq("range_max_err", {done, err}, 3'b101);

    // start and abort together: no scan, err untouched
    @(negedge clk);
    ch_first = 8'd1; ch_last = 8'd2; start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk_eq("start_abort_busy", {busy, done}, 0);
    idle(5);
    chk_eq("start_abort_err_kept", {busy, err}, 3'b001);

    // Normal range 3..5
    exp_wr = '{32'h003, 32'h103, 32'h004, 32'h104, 32'h005, 32'h105, 32'h005};
    exp_ch = '{8'd3, 8'd4, 8'd5};
    n_strobe = 0; n_done = 0;
    do_start(8'd3, 8'd5, 1'b0, 1'b1);
    wait_done(2000);
    chk_eq("normal_err", err, 0);
    end_test();
    chk_eq("normal_strobes", n_strobe, 3);
    chk_eq("normal_done_count", n_done, 1);

    // On-timeout: mux never goes active
    mode = 1;
    exp_wr = '{32'h009, 32'h109, 32'h009};
    n_done = 0; n_strobe = 0;
    do_start(8'd9, 8'd9, 1'b0, 1'b1);
    wait_done(600);
    chk_eq("on_timeout_err", err, 3);
    end_test();
    chk_eq("on_timeout_done_count", n_done, 1);
    chk_eq("on_timeout_no_strobe", n_strobe, 0);
    mode = 0;

    // Wrong-channel echo keeps polling until timeout
    mode = 2;
    exp_wr = '{32'h014, 32'h114, 32'h014};
    n_done = 0; rd0 = rd_count;
    do_start(8'd20, 8'd21, 1'b0, 1'b1);
    wait_done(600);
    chk_eq("echo_err", err, 3);
    chk_eq("echo_kept_polling", (rd_count - rd0) >= 15, 1);
    end_test();
    mode = 0;

    // Continuous wrap at CH_MAX, abort during SETTLE of the fourth channel
    c = 8'd155;
    for (int i = 0; i < 4; i++) begin
      exp_wr.push_back(wword(1'b0, c));
      exp_wr.push_back(wword(1'b1, c));
      if (i < 3) exp_ch.push_back(c);
      if (i < 3) c = (c < 8'd156) ? c + 8'd1 : 8'd155;
    end
    exp_wr.push_back(wword(1'b0, c));
    n_done = 0; n_strobe = 0;
    do_start(8'd155, 8'd156, 1'b1, 1'b1);
    k = 0;
    while (n_strobe < 3 && k < 2000) begin @(negedge clk); k++; end
    chk_eq("wrap_three_strobes", n_strobe, 3);
    k = 0;
    while (!(data_in_1_sel && !rd_wr && ad_from_tuvv[9:8] == 2'b11 && ad_from_tuvv[7:0] == cur_ch)
           && k < 500) begin
      @(negedge clk); k++;
    end
    chk_eq("wrap_fourth_channel", cur_ch, 156);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    wait_done(10);
    chk_eq("wrap_abort_err", err, 0);
    end_test();
    chk_eq("wrap_done_count", n_done, 1);
    chk_eq("wrap_strobes_after_abort", n_strobe, 3);

    // Reset during POLL_ON, then a normal scan
    exp_wr = '{32'h028, 32'h128};
    do_start(8'd40, 8'd40, 1'b0, 1'b1);
    k = 0;
    while (exp_wr.size() != 0 && k < 200) begin @(negedge clk); k++; end
    idle(3);
    rst = 1'b1;
    @(negedge clk);
    chk_eq("midscan_reset_outputs",
           {data_in_1_sel, rd_wr, valid_pci, busy, meas_strobe, done, err, cur_ch, ad_to_tuvv}, 0);
    rst = 1'b0;
    idle(15);
    exp_wr = '{32'h028, 32'h128, 32'h028};
    exp_ch = '{8'd40};
    n_done = 0; n_strobe = 0;
    do_start(8'd40, 8'd40, 1'b0, 1'b1);
    wait_done(1000);
    chk_eq("after_reset_err", err, 0);
    end_test();
    chk_eq("after_reset_strobes", n_strobe, 1);
    chk_eq("after_reset_done_count", n_done, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
